vga_pattern_sequencer: RTL and testbench

- Sits between the VGA sync generator and the 6-bit colour pins, and owns the colour datapath.
- Per pixel, it computes one of four test patterns from the pixel coordinates and blanks outside active video.
- It delays hsync/vsync to match its 2-stage pipeline.
- It sequences patterns frame-by-frame: it auto-advances on a frame-count timeout and advances manually on a push-button, switching only at frame boundaries.

---
 rtl/vga_pattern_sequencer_pkg.sv | 25 ++
 rtl/vga_pattern_sequencer_if.sv | 27 ++
 rtl/vga_pattern_sequencer_sync_edge.sv | 28 ++
 rtl/vga_pattern_sequencer.sv | 149 ++++++++++++++
 tb/tb_vga_pattern_sequencer.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pattern_sequencer_pkg.sv
// Shared types and constants for the VGA pattern sequencer: pattern states,
// colour width and default active-area geometry.
package vga_pkg;

  localparam int COLOR_W      = 6;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  typedef enum logic [1:0] {
    BARS     = 2'd0,
    GRID     = 2'd1,
    GRADIENT = 2'd2,
    CHECKER  = 2'd3
  } pattern_e;

  function automatic pattern_e nextPattern(pattern_e p);
    case (p)
      BARS:     return GRID;
      GRID:     return GRADIENT;
      GRADIENT: return CHECKER;
      default:  return BARS;
    endcase
  endfunction

endpackage

// File: rtl/vga_pattern_sequencer_if.sv
// Pixel-stream bundle between the sync generator, the pattern sequencer and
// the colour pins.
interface vga_pattern_sequencer_if;
  import vga_pkg::*;

  logic [9:0]         x_px;
  logic [9:0]         y_px;
  logic               activevideo;
  logic               hsync_in;
  logic               vsync_in;
  logic               hsync;
  logic               vsync;
  logic [COLOR_W-1:0] color;
  logic [1:0]         pattern;
  logic               led;

  modport master (
    output x_px, y_px, activevideo, hsync_in, vsync_in,
    input  hsync, vsync, color, pattern, led
  );

  modport slave (
    input  x_px, y_px, activevideo, hsync_in, vsync_in,
    output hsync, vsync, color, pattern, led
  );

endinterface

// File: rtl/vga_pattern_sequencer_sync_edge.sv
// Two-flop synchroniser for an asynchronous level, followed by a one-cycle
// pulse on each synchronised rising edge.
module sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic async_i,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic last_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      last_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      last_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~last_q;

endmodule

// File: rtl/vga_pattern_sequencer.sv
// Test-pattern colour datapath: two-stage pixel pipeline with delayed syncs and
// a frame-synchronous pattern sequencer driven by a timeout or a push-button.
module vga_pattern_sequencer
  import vga_pkg::*;
#(
  parameter int FRAMES_PER_PATTERN = 120,
  parameter int H_ACTIVE           = H_ACTIVE_DEF,
  parameter int V_ACTIVE           = V_ACTIVE_DEF,
  parameter bit VSYNC_ACTIVE_LOW   = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   next_btn,
  input  logic                   auto_en,
  vga_pattern_sequencer_if.slave vga
);

  localparam logic       SYNC_IDLE  = VSYNC_ACTIVE_LOW;
  localparam logic [7:0] LAST_FRAME = 8'(FRAMES_PER_PATTERN - 1);
  localparam logic [9:0] X_LAST     = 10'(H_ACTIVE - 1);
  localparam logic [9:0] Y_LAST     = 10'(V_ACTIVE - 1);

  logic [9:0]         x1_q;
  logic [9:0]         y1_q;
  logic               av1_q;
  logic               hs1_q;
  logic               vs1_q;
  logic               st1Valid_q;
  logic               vsPrevActive_q;
  logic [COLOR_W-1:0] color_q;
  logic [COLOR_W-1:0] color_d;
  logic               hs2_q;
  logic               vs2_q;
  pattern_e           pattern_q;
  pattern_e           pattern_d;
  logic [7:0]         frameCnt_q;
  logic [7:0]         frameCnt_d;
  logic               btnPending_q;
  logic               btnPending_d;
  logic               led_q;
  logic               led_d;
  logic               btnRise;
  logic               vs1Active;
  logic               boundary;
  logic               advance;

  sync_edge u_btn_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .async_i (next_btn),
    .rise_o  (btnRise)
  );

  function automatic logic [COLOR_W-1:0] patternColor(
    pattern_e   p,
    logic [9:0] x,
    logic [9:0] y,
    logic [1:0] cntHi
  );
    logic [2:0] bar;
    bar = x[8:6];
    case (p)
      BARS:     return {bar[2], bar[2], bar[1], bar[1], bar[0], bar[0]};
      GRID:     return (x[4:0] == 5'd0 || y[4:0] == 5'd0 || x == X_LAST || y == Y_LAST)
                       ? {COLOR_W{1'b1}} : '0;
      GRADIENT: return {x[8:7], y[7:6], cntHi};
      default:  return (x[5] ^ y[5]) ? {COLOR_W{1'b1}} : '0;
    endcase
  endfunction

  // The previous-vsync flag resets to "active" so a vsync already asserted at
  // release must deassert and reassert before it counts as a frame boundary.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x1_q           <= '0;
      y1_q           <= '0;
      av1_q          <= 1'b0;
      hs1_q          <= SYNC_IDLE;
      vs1_q          <= SYNC_IDLE;
      st1Valid_q     <= 1'b0;
      vsPrevActive_q <= 1'b1;
    end else begin
      x1_q           <= vga.x_px;
      y1_q           <= vga.y_px;
      av1_q          <= vga.activevideo;
      hs1_q          <= vga.hsync_in;
      vs1_q          <= vga.vsync_in;
      st1Valid_q     <= 1'b1;
      vsPrevActive_q <= st1Valid_q ? vs1Active : 1'b1;
    end
  end

  assign vs1Active = (vs1_q != SYNC_IDLE);
  assign boundary  = vs1Active && !vsPrevActive_q;
  assign advance   = (auto_en && frameCnt_q == LAST_FRAME) || btnPending_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pattern_q    <= BARS;
      frameCnt_q   <= '0;
      btnPending_q <= 1'b0;
      led_q        <= 1'b0;
    end else begin
      pattern_q    <= pattern_d;
      frameCnt_q   <= frameCnt_d;
      btnPending_q <= btnPending_d;
      led_q        <= led_d;
    end
  end

  // A press arriving in the boundary cycle itself stays pending for the next frame.
  always_comb begin
    pattern_d    = pattern_q;
    frameCnt_d   = frameCnt_q;
    btnPending_d = btnPending_q || btnRise;
    led_d        = led_q;
    if (boundary) begin
      led_d        = ~led_q;
      btnPending_d = btnRise;
      if (advance) begin
        pattern_d  = nextPattern(pattern_q);
        frameCnt_d = '0;
      end else if (frameCnt_q != 8'hFF) begin
        frameCnt_d = frameCnt_q + 8'd1;
      end
    end
  end

  assign color_d = av1_q ? patternColor(pattern_q, x1_q, y1_q, frameCnt_q[5:4]) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      color_q <= '0;
      hs2_q   <= SYNC_IDLE;
      vs2_q   <= SYNC_IDLE;
    end else begin
      color_q <= color_d;
      hs2_q   <= hs1_q;
      vs2_q   <= vs1_q;
    end
  end

  assign vga.color   = color_q;
  assign vga.hsync   = hs2_q;
  assign vga.vsync   = vs2_q;
  assign vga.pattern = pattern_q;
  assign vga.led     = led_q;

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Randomised scoreboard bench for vga_pattern_sequencer: a frame-level model
// predicts every output two clocks after each driven pixel.
module tb_vga_pattern_sequencer;
  import vga_pkg::*;

  localparam int FPP       = 3;
  localparam int FRAME_LEN = 32;
  localparam int VS_LEN    = 3;
  localparam int NDIR      = 9;

  logic clk      = 1'b0;
  logic reset_n  = 1'b0;
  logic next_btn = 1'b0;
  logic auto_en  = 1'b0;

  vga_pattern_sequencer_if vif ();

  vga_pattern_sequencer #(
    .FRAMES_PER_PATTERN (FPP),
    .H_ACTIVE           (640),
    .V_ACTIVE           (480),
    .VSYNC_ACTIVE_LOW   (1'b1)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .next_btn (next_btn),
    .auto_en  (auto_en),
    .vga      (vif)
  );

  always #5 clk = ~clk;

  int unsigned cycle = 0;
  always @(posedge clk) cycle++;

  typedef struct {
    int unsigned due;
    logic [5:0]  color;
    logic        hs;
    logic        vs;
    logic [1:0]  pat;
    logic        led;
  } exp_t;

  exp_t scoreQ[$];
  int   errors = 0;
  int   checks = 0;

  // Behavioural model state: pattern index, frames shown, pending press, led.
  int mPat;
  int mCnt;
  int mPendEligible;
  bit mLed;
  bit mPrevActive;
  bit mLastBtn;
  bit mAuto;
  bit releasePending = 1'b0;

  int dirX  [NDIR] = '{130, 32, 33, 32,  32, 384, 639, 100, 130};
  int dirY  [NDIR] = '{ 10,  7,  7,  0,  32, 192, 100, 479,  10};
  bit dirAv [NDIR] = '{  1,  1,  1,  1,   1,   1,   1,   1,   0};

  function automatic logic [5:0] refColor(int p, int x, int y, int cnt);
    int bar;
    case (p)
      0: begin
        bar = (x / 64) % 8;
        return 6'((bar / 4) * 48 + ((bar / 2) % 2) * 12 + (bar % 2) * 3);
      end
      1: return ((x % 32 == 0) || (y % 32 == 0) || x == 639 || y == 479) ? 6'h3F : 6'h00;
      2: return 6'(((x / 128) % 4) * 16 + ((y / 64) % 4) * 4 + (cnt / 16) % 4);
      default: return (((x / 32) % 2) != ((y / 32) % 2)) ? 6'h3F : 6'h00;
    endcase
  endfunction

  task automatic resetModel();
    mPat          = 0;
    mCnt          = 0;
    mPendEligible = -1;
    mLed          = 1'b0;
    mPrevActive   = 1'b1;
    mLastBtn      = 1'b0;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, actual, expected, cycle);
    end
  endtask

  // Drive one pixel and let the model decide what the DUT shows two clocks later.
  task automatic applyStimulus(input int x, input int y, input bit av, input bit hs,
                               input bit vs, input bit btn);
    exp_t e;
    bit   vsActive;
    bit   adv;
    @(posedge clk);
    #1;
    if (releasePending) begin
      reset_n        = 1'b1;
      releasePending = 1'b0;
    end
    vif.x_px        = 10'(x);
    vif.y_px        = 10'(y);
    vif.activevideo = av;
    vif.hsync_in    = hs;
    vif.vsync_in    = vs;
    next_btn        = btn;
    auto_en         = mAuto;

    if (btn && !mLastBtn && mPendEligible < 0) mPendEligible = int'(cycle) + 2;
    mLastBtn = btn;

    e.due   = cycle + 2;
    e.color = av ? refColor(mPat, x, y, mCnt) : 6'h00;
    e.hs    = hs;
    e.vs    = vs;

    vsActive = !vs;
    if (vsActive && !mPrevActive) begin
      mLed = !mLed;
      adv  = (mAuto && mCnt == FPP - 1);
      if (mPendEligible >= 0 && int'(cycle) >= mPendEligible) begin
        adv           = 1'b1;
        mPendEligible = -1;
      end
      if (adv) begin
        mPat = (mPat + 1) % 4;
        mCnt = 0;
      end else if (mCnt < 255) begin
        mCnt++;
      end
    end
    mPrevActive = vsActive;

    e.pat = 2'(mPat);
    e.led = mLed;
    scoreQ.push_back(e);
  endtask

  task automatic runFrame(input int presses, input int firstC);
    int x, y;
    bit av, btn;
    for (int c = firstC; c < FRAME_LEN; c++) begin
      btn = 1'b0;
      for (int p = 0; p < presses; p++)
        if (c >= 6 + 6 * p && c < 9 + 6 * p) btn = 1'b1;
      if (c >= 4 && c - 4 < NDIR) begin
        x  = dirX[c - 4];
        y  = dirY[c - 4];
        av = dirAv[c - 4];
      end else begin
        x  = (($urandom_range(0, 3) == 0) ? 639 : int'($urandom_range(0, 1023)));
        y  = (($urandom_range(0, 3) == 0) ? 479 : int'($urandom_range(0, 1023)));
        av = ($urandom_range(0, 3) != 0);
      end
      applyStimulus(x, y, av, 1'($urandom_range(0, 1)), (c < VS_LEN) ? 1'b0 : 1'b1, btn);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " color"},   int'(vif.color),   0);
    checkOutput({tag, " hsync"},   int'(vif.hsync),   1);
    checkOutput({tag, " vsync"},   int'(vif.vsync),   1);
    checkOutput({tag, " pattern"}, int'(vif.pattern), 0);
    checkOutput({tag, " led"},     int'(vif.led),     0);
  endtask

  // Monitor: every cycle the DUT presents a pixel; compare against the due entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (scoreQ.size() > 0 && scoreQ[0].due < cycle) begin
        e = scoreQ.pop_front();
        checkOutput("stale expectation", int'(e.due), int'(cycle));
      end
      if (scoreQ.size() > 0 && scoreQ[0].due == cycle) begin
        e = scoreQ.pop_front();
        checkOutput("color",   int'(vif.color),   int'(e.color));
        checkOutput("hsync",   int'(vif.hsync),   int'(e.hs));
        checkOutput("vsync",   int'(vif.vsync),   int'(e.vs));
        checkOutput("pattern", int'(vif.pattern), int'(e.pat));
        checkOutput("led",     int'(vif.led),     int'(e.led));
      end
    end
  end

  initial begin
    vif.x_px        = '0;
    vif.y_px        = '0;
    vif.activevideo = 1'b0;
    vif.hsync_in    = 1'b1;
    vif.vsync_in    = 1'b1;
    mAuto           = 1'b0;
    resetModel();
    $display("[TB] start");

    repeat (3) @(posedge clk);
    #2;
    checkResetState("power-on reset");

    // Release with vsync already active: no boundary until it reasserts.
    releasePending = 1'b1;
    repeat (2) runFrame(0, 0);

    mAuto = 1'b1;
    repeat (14) runFrame(0, 0);

    mAuto = 1'b0;
    runFrame(3, 0);
    repeat (3) runFrame(0, 0);

    // Long manual stretch: frame counter must saturate without advancing.
    repeat (300) runFrame(0, 0);

    mAuto = 1'b1;
    repeat (3) runFrame(0, 0);
    runFrame(1, 0);
    repeat (2) runFrame(0, 0);
    runFrame(1, 0);
    repeat (4) runFrame(0, 0);

    // Mid-frame asynchronous reset, released while vsync is inactive.
    for (int c = 0; c < 16; c++)
      applyStimulus(130, 10, 1'b1, 1'b0, (c < VS_LEN) ? 1'b0 : 1'b1, 1'b0);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    scoreQ.delete();
    resetModel();
    #1;
    checkResetState("mid-frame reset");
    repeat (2) @(posedge clk);
    releasePending = 1'b1;
    runFrame(0, 16);
    repeat (5) runFrame(0, 0);

    repeat (4) @(posedge clk);
    #2;
    checkOutput("scoreboard drained", scoreQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
